uart_cmd_decoder: RTL and testbench

Packet parser sitting directly downstream of the UART receive path. Consumes validated 9-bit receive frames (8 data bits plus a parity-error flag) and assembles fixed-length command packets. Each checksum-verified packet becomes a single-cycle register-write strobe toward the VGA configuration registers. Malformed, corrupted or stalled packets are discarded and counted.

---
 rtl/uart_cmd_decoder.sv | 193 +++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 5-byte command packets (SYNC, ADDR, DHI, DLO, CSUM)
// from validated UART receive frames and issues one register-write strobe per
// checksum-verified packet. Corrupted, malformed or stalled packets are dropped
// and counted in a saturating error counter.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   frame[8:0]   [7:0] data byte, [8] upstream parity-error flag (1 = bad)
//   frame_valid  one-cycle qualifier for frame
//   wr_en        one-cycle register-write strobe
//   wr_addr      register address, held until the next write
//   wr_data      register data {DHI, DLO}, held until the next write
//   pkt_err      one-cycle pulse per discarded packet
//   err_count    saturating count of discarded packets
//   busy         high while a packet is partially received
//
// Build option: define UART_CMD_TIMEOUT_EN to abort packets whose next byte
// does not arrive within TIMEOUT_CYCLES clocks.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  frame,
  input  logic        frame_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        pkt_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 20;

  typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CSUM} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   dhi_q, dhi_d;
  logic [BYTE_W-1:0]   dlo_q, dlo_d;
  logic [BYTE_W-1:0]   xor_q, xor_d;
  logic                wr_en_d, pkt_err_d, busy_d;
  logic [BYTE_W-1:0]   wr_addr_d, err_count_d;
  logic [2*BYTE_W-1:0] wr_data_d;
  logic                drop;
  logic                timeout_c;

  logic [BYTE_W-1:0] byte_in;
  logic              bad;
  assign byte_in = frame[7:0];
  assign bad     = frame[8];

`ifdef UART_CMD_TIMEOUT_EN
  logic [CNT_W-1:0] gap_cnt;

  // Inter-byte gap counter; only runs while a packet is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (frame_valid || state_q == IDLE) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

  // A frame arriving in the expiry cycle takes precedence over the timeout.
  assign timeout_c = (state_q != IDLE) && !frame_valid &&
                     (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && (CNT_W != 0);
  assign timeout_c          = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      xor_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pkt_err   <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      xor_q     <= xor_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      pkt_err   <= pkt_err_d;
      err_count <= err_count_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    xor_d       = xor_q;
    wr_en_d     = 1'b0;
    pkt_err_d   = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    err_count_d = err_count;
    drop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Noise and flagged frames are ignored without counting.
        if (frame_valid && !bad && byte_in == SYNC_BYTE) begin
          state_d = ADDR;
          xor_d   = '0;
        end
      end
      ADDR: begin
        if (frame_valid) begin
          if (bad) begin
            drop = 1'b1;
          end else begin
            addr_d  = byte_in;
            xor_d   = xor_q ^ byte_in;
            state_d = DHI;
          end
        end
      end
      DHI: begin
        if (frame_valid) begin
          if (bad) begin
            drop = 1'b1;
          end else begin
            dhi_d   = byte_in;
            xor_d   = xor_q ^ byte_in;
            state_d = DLO;
          end
        end
      end
      DLO: begin
        if (frame_valid) begin
          if (bad) begin
            drop = 1'b1;
          end else begin
            dlo_d   = byte_in;
            xor_d   = xor_q ^ byte_in;
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (frame_valid) begin
          if (!bad && byte_in == xor_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {dhi_q, dlo_q};
            state_d   = IDLE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      drop = 1'b1;
    end

    // Any abort returns to IDLE; the aborting byte is never re-examined as SYNC.
    if (drop) begin
      state_d     = IDLE;
      pkt_err_d   = 1'b1;
      err_count_d = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes the expected write or
// error event; a negedge monitor pops and compares on every wr_en/pkt_err.
module tb_uart_cmd_decoder;

  typedef struct packed {
    logic        is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  frame;
  logic        frame_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pkt_err;
  logic [7:0]  err_count;
  logic        busy;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic [7:0]  m_cnt  = 8'h00;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(100), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_err(pkt_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic send(input logic flag, input logic [7:0] b);
    frame       = {flag, b};
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    frame       = 9'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [15:0] d);
    m_addr = a;
    m_data = d;
    sb.push_back('{1'b1, a, d, m_cnt});
  endtask

  task automatic exp_err();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    sb.push_back('{1'b0, m_addr, m_data, m_cnt});
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                     input logic [7:0] c);
    send(1'b0, 8'hA5);
    send(1'b0, a);
    send(1'b0, h);
    send(1'b0, l);
    send(1'b0, c);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (wr_en || pkt_err)) begin
      check("wr_en_pkt_err_exclusive", 32'(wr_en & pkt_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {wr_en, pkt_err, wr_addr, wr_data}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {30'd0, wr_en, pkt_err}, {30'd0, e.is_wr, ~e.is_wr});
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("err_count", 32'(err_count), 32'(e.cnt));
        check("busy_at_strobe", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    frame       = 9'h000;
    frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {7'd0, wr_en, pkt_err, busy, wr_addr, err_count, 6'd0},
          32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b1;
    idle(2);

    // Good packet.
    send(1'b0, 8'hA5);
    @(negedge clk);
    check("busy_after_sync", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 8'h10);
    send(1'b0, 8'h12);
    send(1'b0, 8'h34);
    exp_wr(8'h10, 16'h1234);
    send(1'b0, 8'h36);
    idle(2);

    // Bad checksum.
    exp_err();
    pkt(8'h10, 8'h12, 8'h34, 8'h00);
    idle(2);

    // Noise in IDLE, then SYNC values carried as data.
    send(1'b0, 8'h00);
    send(1'b0, 8'hFF);
    send(1'b0, 8'h5A);
    @(negedge clk);
    check("busy_after_noise", 32'(busy), 32'd0);
    check("count_after_noise", 32'(err_count), 32'(m_cnt));
    @(posedge clk); #1;
    exp_wr(8'h01, 16'hA5A5);
    pkt(8'h01, 8'hA5, 8'hA5, 8'h01);
    idle(2);

    // Parity abort mid-packet, then a clean packet.
    send(1'b0, 8'hA5);
    send(1'b0, 8'h20);
    exp_err();
    send(1'b1, 8'h00);
    @(negedge clk);
    check("busy_after_abort", 32'(busy), 32'd0);
    @(posedge clk); #1;
    exp_wr(8'h7E, 16'h00FF);
    pkt(8'h7E, 8'h00, 8'hFF, 8'h81);
    idle(2);

    // Back-to-back packets.
    exp_wr(8'h11, 16'h2233);
    exp_wr(8'h44, 16'h5566);
    pkt(8'h11, 8'h22, 8'h33, 8'h00);
    pkt(8'h44, 8'h55, 8'h66, 8'h77);
    idle(2);

    // Flagged SYNC in IDLE is ignored; following bytes are noise.
    send(1'b1, 8'hA5);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b0, 8'h00);
    idle(1);
    check("busy_after_flagged_sync", 32'(busy), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    // Stall after ADDR: timeout aborts the packet.
    send(1'b0, 8'hA5);
    send(1'b0, 8'h10);
    exp_err();
    idle(100);
    idle(1);
    check("busy_after_timeout", 32'(busy), 32'd0);
    // Byte in the 99th idle cycle continues the packet.
    send(1'b0, 8'hA5);
    send(1'b0, 8'h10);
    idle(98);
    send(1'b0, 8'h12);
    send(1'b0, 8'h34);
    exp_wr(8'h10, 16'h1234);
    send(1'b0, 8'h36);
    idle(2);
`endif

    // Saturation over 300 bad packets.
    for (int i = 0; i < 300; i++) begin
      exp_err();
      pkt(8'h01, 8'h02, 8'h03, 8'hFF);
    end
    idle(2);
    check("err_count_saturated", 32'(err_count), 32'd255);

    // Async reset mid-packet.
    send(1'b0, 8'hA5);
    send(1'b0, 8'h10);
    #2;
    rst = 1'b0;
    #1;
    check("midpkt_reset_outputs", {7'd0, wr_en, pkt_err, busy, wr_addr, err_count, 6'd0},
          32'd0);
    check("midpkt_reset_wr_data", 32'(wr_data), 32'd0);
    m_addr = 8'h00;
    m_data = 16'h0000;
    m_cnt  = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    exp_wr(8'h10, 16'h1234);
    pkt(8'h10, 8'h12, 8'h34, 8'h36);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
